// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: port IDs, tag entry and
// the default memory geometry used by the CPU top.
package dmem_arbiter_pkg;

  localparam int DMEM_ADDR_W = 20;
  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_RD_LAT = 2;

  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } dmem_tag_t;

endpackage

// File: rtl/dmem_tag_pipe.sv
// Valid/port shift register that tracks in-flight reads so returning memory
// data can be steered to the port that issued it.
module dmem_tag_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic      clk,
  input  logic      rstn,
  input  dmem_tag_t push_i,
  output dmem_tag_t tail_o
);

  dmem_tag_t stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= push_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tail_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// load/store path (port 0) and the UART loader (port 1).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W,
  parameter int RD_LAT = DMEM_RD_LAT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ready_o,
  output logic              m0_rvalid_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ready_o,
  output logic              m1_rvalid_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  // Handshake: a requester holds req/we/addr/wdata stable until it sees
  // ready=1; the command is accepted in that cycle. rvalid is a one-cycle
  // pulse with no back-pressure; rdata is meaningful only while rvalid=1.

  logic              last_grant_q, last_grant_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              grant0, grant1, any_grant;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  dmem_tag_t         tag_push, tag_tail;

  // On a tie the port that did not win last time goes next.
  assign grant0    = rstn & m0_req_i & (~m1_req_i | (last_grant_q == PORT_LOADER));
  assign grant1    = rstn & m1_req_i & (~m0_req_i | (last_grant_q == PORT_CPU));
  assign any_grant = grant0 | grant1;

  assign cmd_we    = grant1 ? m1_we_i    : m0_we_i;
  assign cmd_addr  = grant1 ? m1_addr_i  : m0_addr_i;
  assign cmd_wdata = grant1 ? m1_wdata_i : m0_wdata_i;

  always_comb begin
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    last_grant_d = last_grant_q;
    if (any_grant) begin
      mem_we_d     = cmd_we;
      mem_addr_d   = cmd_addr;
      mem_wdata_d  = cmd_wdata;
      last_grant_d = grant1 ? PORT_LOADER : PORT_CPU;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      last_grant_q <= PORT_LOADER;
    end else begin
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    tag_push       = '0;
    tag_push.valid = any_grant & ~cmd_we;
    tag_push.port  = grant1 ? PORT_LOADER : PORT_CPU;
  end

  // One stage for the command register plus RD_LAT stages of memory latency.
  dmem_tag_pipe #(
    .DEPTH (1 + RD_LAT)
  ) u_tag_pipe (
    .clk    (clk),
    .rstn   (rstn),
    .push_i (tag_push),
    .tail_o (tag_tail)
  );

  assign m0_ready_o  = grant0;
  assign m1_ready_o  = grant1;
  assign m0_rvalid_o = tag_tail.valid & (tag_tail.port == PORT_CPU);
  assign m1_rvalid_o = tag_tail.valid & (tag_tail.port == PORT_LOADER);
  assign m0_rdata_o  = mem_rdata_i;
  assign m1_rdata_o  = mem_rdata_i;

  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory with 2-cycle read latency,
// per-port expected-read-data queues, directed scenarios and a random phase.
module tb_dmem_arbiter;

  localparam int AW = 20;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          m0_req, m0_we, m0_ready, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_ready, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .RD_LAT (2)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .m0_req_i    (m0_req),
    .m0_we_i     (m0_we),
    .m0_addr_i   (m0_addr),
    .m0_wdata_i  (m0_wdata),
    .m0_ready_o  (m0_ready),
    .m0_rvalid_o (m0_rvalid),
    .m0_rdata_o  (m0_rdata),
    .m1_req_i    (m1_req),
    .m1_we_i     (m1_we),
    .m1_addr_i   (m1_addr),
    .m1_wdata_i  (m1_wdata),
    .m1_ready_o  (m1_ready),
    .m1_rvalid_o (m1_rvalid),
    .m1_rdata_o  (m1_rdata),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  // Memory model: read-first single port, data two cycles after the command.
  logic [DW-1:0] mem_model [0:1023];
  logic [DW-1:0] shadow    [0:1023];
  logic [DW-1:0] rd_p0, rd_p1;

  assign mem_rdata = rd_p1;

  always @(posedge clk) begin
    rd_p0 <= mem_model[mem_addr[9:0]];
    rd_p1 <= rd_p0;
    if (mem_we) mem_model[mem_addr[9:0]] <= mem_wdata;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Scoreboard: expected read data pushed at acceptance, popped on rvalid.
  logic [DW-1:0] exp0_q[$];
  logic [DW-1:0] exp1_q[$];

  always @(negedge clk) begin
    if (!rstn) begin
      exp0_q.delete();
      exp1_q.delete();
    end else begin
      if (m0_rvalid) begin
        if (exp0_q.size() == 0) check("m0_extra_rvalid", 1, 0);
        else check("m0_rdata", m0_rdata, exp0_q.pop_front());
      end
      if (m1_rvalid) begin
        if (exp1_q.size() == 0) check("m1_extra_rvalid", 1, 0);
        else check("m1_rdata", m1_rdata, exp1_q.pop_front());
      end
      if (m0_ready) begin
        if (m0_we) shadow[m0_addr[9:0]] = m0_wdata;
        else exp0_q.push_back(shadow[m0_addr[9:0]]);
      end
      if (m1_ready) begin
        if (m1_we) shadow[m1_addr[9:0]] = m1_wdata;
        else exp1_q.push_back(shadow[m1_addr[9:0]]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    m0_req = 1'b0; m0_we = 1'b0;
    m1_req = 1'b0; m1_we = 1'b0;
  endtask

  task automatic preload(input int a, input logic [DW-1:0] d);
    mem_model[a] = d;
    shadow[a]    = d;
  endtask

  task automatic drive_m0(input logic we, input int a, input logic [DW-1:0] d);
    m0_req = 1'b1; m0_we = we; m0_addr = AW'(a); m0_wdata = d;
  endtask

  task automatic drive_m1(input logic we, input int a, input logic [DW-1:0] d);
    m1_req = 1'b1; m1_we = we; m1_addr = AW'(a); m1_wdata = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [DW-1:0] v1, v2, v3;
    logic          lg, acc0, acc1;

    for (int i = 0; i < 1024; i++) begin
      mem_model[i] = '0;
      shadow[i]    = '0;
    end
    idle();
    m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;

    // Reset with both ports requesting: no ready, command register cleared.
    rstn = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1;
    repeat (3) step();
    sample();
    check("rst_m0_ready", m0_ready, 0);
    check("rst_m1_ready", m1_ready, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_m1_rvalid", m1_rvalid, 0);
    step();

    // Tie-break after reset then strict alternation.
    rstn = 1'b1;
    drive_m0(1'b0, 32'h100, '0);
    drive_m1(1'b0, 32'h200, '0);
    for (int i = 0; i < 8; i++) begin
      sample();
      check("tie_m0_ready", m0_ready, (i % 2 == 0));
      check("tie_m1_ready", m1_ready, (i % 2 == 1));
      step();
      if (i % 2 == 0) m0_addr = AW'($urandom_range(0, 1023));
      else            m1_addr = AW'($urandom_range(0, 1023));
    end
    idle();
    repeat (4) step();

    // Single read.
    preload(32'h10, 32'hDEADBEEF);
    drive_m0(1'b0, 32'h10, '0);
    sample();
    check("single_m0_ready", m0_ready, 1);
    step(); idle();
    sample();
    check("single_mem_addr", mem_addr, 32'h10);
    check("single_mem_we", mem_we, 0);
    step();
    sample();
    check("single_early_rvalid", m0_rvalid, 0);
    step();
    sample();
    check("single_rvalid", m0_rvalid, 1);
    check("single_rdata", m0_rdata, 32'hDEADBEEF);
    check("single_m1_rvalid", m1_rvalid, 0);
    step();
    sample();
    check("single_rvalid_once", m0_rvalid, 0);
    step();

    // Write on port 1 then read of the same address on port 0.
    drive_m1(1'b1, 32'h20, 32'h12345678);
    sample();
    check("wr_m1_ready", m1_ready, 1);
    step();
    m1_req = 1'b0; m1_we = 1'b0;
    drive_m0(1'b0, 32'h20, '0);
    sample();
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 32'h20);
    check("wr_mem_wdata", mem_wdata, 32'h12345678);
    check("rd_m0_ready", m0_ready, 1);
    step(); idle();
    sample();
    check("wr_mem_we_once", mem_we, 0);
    step();
    sample();
    step();
    sample();
    check("wr_rd_rvalid", m0_rvalid, 1);
    check("wr_rd_rdata", m0_rdata, 32'h12345678);
    step();
    repeat (3) step();

    // Back-to-back reads on port 0.
    v1 = $urandom; v2 = $urandom; v3 = $urandom;
    preload(1, v1); preload(2, v2); preload(3, v3);
    drive_m0(1'b0, 1, '0);
    sample(); check("b2b_ready_1", m0_ready, 1); step();
    drive_m0(1'b0, 2, '0);
    sample(); check("b2b_ready_2", m0_ready, 1); step();
    drive_m0(1'b0, 3, '0);
    sample(); check("b2b_ready_3", m0_ready, 1); step();
    idle();
    sample(); check("b2b_rvalid_1", m0_rvalid, 1); check("b2b_rdata_1", m0_rdata, v1); step();
    sample(); check("b2b_rvalid_2", m0_rvalid, 1); check("b2b_rdata_2", m0_rdata, v2); step();
    sample(); check("b2b_rvalid_3", m0_rvalid, 1); check("b2b_rdata_3", m0_rdata, v3); step();
    sample(); check("b2b_rvalid_end", m0_rvalid, 0); step();

    // Port 1 pulses a write for one cycle while losing to port 0.
    preload(32'h30, 32'hC0FFEE30);
    preload(32'h31, 32'hC0FFEE31);
    preload(32'h77, 32'h55555555);
    drive_m1(1'b0, 32'h30, '0);
    sample(); check("wd_m1_ready", m1_ready, 1); step();
    drive_m1(1'b1, 32'h77, 32'hBAD0BAD0);
    drive_m0(1'b0, 32'h31, '0);
    sample();
    check("wd_m0_ready", m0_ready, 1);
    check("wd_m1_ready_lost", m1_ready, 0);
    step(); idle();
    sample();
    check("wd_mem_addr", mem_addr, 32'h31);
    check("wd_mem_we", mem_we, 0);
    step();
    sample();
    check("wd_idle_mem_we", mem_we, 0);
    check("wd_idle_addr_hold", mem_addr, 32'h31);
    check("wd_m1_rvalid", m1_rvalid, 1);
    step();
    sample();
    check("wd_m0_rvalid", m0_rvalid, 1);
    check("wd_no_m1_rvalid", m1_rvalid, 0);
    step();
    repeat (2) step();
    check("wd_no_write", mem_model[32'h77], 32'h55555555);

    // Reset with a read in flight.
    preload(32'h40, 32'h40404040);
    drive_m0(1'b0, 32'h40, '0);
    sample(); check("rmf_m0_ready", m0_ready, 1); step();
    rstn = 1'b0; idle(); m1_req = 1'b1;
    sample(); check("rmf_ready_in_reset", m1_ready, 0); step();
    rstn = 1'b1; idle();
    sample();
    check("rmf_mem_we", mem_we, 0);
    check("rmf_mem_addr", mem_addr, 0);
    check("rmf_m0_rvalid_a", m0_rvalid, 0);
    step();
    drive_m0(1'b0, 32'h40, '0);
    drive_m1(1'b0, 32'h31, '0);
    sample();
    check("rmf_m0_rvalid_b", m0_rvalid, 0);
    check("rmf_tie_m0_ready", m0_ready, 1);
    check("rmf_tie_m1_ready", m1_ready, 0);
    step();
    m0_req = 1'b0;
    sample();
    check("rmf_m1_ready", m1_ready, 1);
    step(); idle();
    repeat (4) step();

    // Random traffic with grant-rule checks; data checked by the scoreboard.
    lg = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!m0_req && $urandom_range(0, 3) != 0)
        drive_m0($urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom);
      if (!m1_req && $urandom_range(0, 3) != 0)
        drive_m1($urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom);
      sample();
      check("rr_m0_grant", m0_ready, m0_req && (!m1_req || lg));
      check("rr_m1_grant", m1_ready, m1_req && (!m0_req || !lg));
      acc0 = m0_ready;
      acc1 = m1_ready;
      if (acc0) lg = 1'b0;
      else if (acc1) lg = 1'b1;
      step();
      if (acc0) begin m0_req = 1'b0; m0_we = 1'b0; end
      if (acc1) begin m1_req = 1'b0; m1_we = 1'b0; end
    end
    idle();
    repeat (6) step();
    check("drain_q0", exp0_q.size(), 0);
    check("drain_q1", exp1_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
